// File: rtl/psram_bridge_pkg.sv
// Shared types and constants for the PSRAM command bridge.
// StSendAck exists only when PSRAM_BRIDGE_WRITE_ACK_EN is defined.
package psram_bridge_pkg;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned DATA_W   = 16;
  localparam logic [7:0]  ACK_BYTE = 8'h4B;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StSendHi,
    StSendLo,
    StWrDone,
    StErr
`ifdef PSRAM_BRIDGE_WRITE_ACK_EN
    ,
    StSendAck
`endif
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/psram_cmd_fifo.sv
// Single-clock command FIFO; head is visible combinationally, the consumer registers it on pop.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module psram_cmd_fifo
  import psram_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  cmd_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/psram_cmd_bridge.sv
// Queues UART parser commands and runs them against the PSRAM user port, returning read bytes.
// Define PSRAM_BRIDGE_WRITE_ACK_EN to send ACK_BYTE on the UART after each completed write.
module psram_cmd_bridge
  import psram_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              read_flg,
  input  logic              write_flg,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] message,
  input  logic              calib_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        timeout_cnt
);

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d, fifo_head, push_cmd;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       timer_q, timer_d;
  logic [7:0]        tocnt_q, tocnt_d;
  logic              overflow_q;
  logic              push, fifo_pop, fifo_full, fifo_empty;

  // Both flags together count as a write.
  assign push     = read_flg | write_flg;
  assign push_cmd = cmd_t'{we: write_flg, addr: address, data: message};

  psram_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rdata_d  = rdata_q;
    timer_d  = timer_q;
    tocnt_d  = tocnt_q;
    fifo_pop = 1'b0;
    mem_req  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      StIdle: begin
        if (calib_done && !fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          timer_d  = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          timer_d = '0;
          state_d = cmd_q.we ? StWrDone : StWaitRd;
        end else if (timer_q == TimerLast) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StWaitRd: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = StSendHi;
        end else if (timer_q == TimerLast) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StSendHi: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[15:8];
        if (tx_ready) state_d = StSendLo;
      end
      StSendLo: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[7:0];
        if (tx_ready) state_d = StIdle;
      end
      StWrDone: begin
`ifdef PSRAM_BRIDGE_WRITE_ACK_EN
        state_d = StSendAck;
`else
        state_d = StIdle;
`endif
      end
`ifdef PSRAM_BRIDGE_WRITE_ACK_EN
      StSendAck: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) state_d = StIdle;
      end
`endif
      StErr: begin
        tx_valid = 1'b1;
        tx_data  = ERR_BYTE;
        if (tx_ready) begin
          state_d = StIdle;
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
      tocnt_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      tocnt_q <= tocnt_d;
      if (push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  assign mem_we      = cmd_q.we;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.data;
  assign busy        = !fifo_empty || (state_q != StIdle);
  assign overflow    = overflow_q;
  assign timeout_cnt = tocnt_q;

endmodule

// File: doc/psram_cmd_bridge.md
Name: psram_cmd_bridge

Overview:
- Sits directly downstream of the UART command parser.
- Consumes its one-cycle read_flg/write_flg pulses together with the 24-bit address and 16-bit message.
- Queues the commands, executes them against the PSRAM controller's user port, and returns read data to the UART transmitter as bytes over a valid/ready interface.
- Isolates UART byte timing from PSRAM latency and calibration.

Parameters:
- FIFO_DEPTH, 4: command queue entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1024: max sys_clk cycles from mem_req acceptance to mem_rvalid or write mem_ack.
- ERR_BYTE, 8'h45: byte sent on timeout.

Ports:
- sys_clk, in, 1: system clock, 27 MHz.
- sys_rst, in, 1: synchronous, active-high reset.
- read_flg, in, 1: one-cycle read command pulse from the UART parser.
- write_flg, in, 1: one-cycle write command pulse from the UART parser.
- address, in, 24: PSRAM word address; sampled on a flag pulse.
- message, in, 16: write data; sampled on write_flg.
- calib_done, in, 1: PSRAM controller initialised.
- mem_req, out, 1: request valid.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, 24: request address.
- mem_wdata, out, 16: write data.
- mem_ack, in, 1: controller accepted the request (read) or completed it (write).
- mem_rdata, in, 16: read data.
- mem_rvalid, in, 1: mem_rdata valid, one-cycle pulse.
- tx_data, out, 8: byte to the UART transmitter.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: transmitter accepts the byte this cycle.
- busy, out, 1: FIFO non-empty or FSM not in IDLE.
- overflow, out, 1: sticky; set when a command is dropped because the FIFO is full.
- timeout_cnt, out, 8: saturating count of timeouts.

Behaviour:
- Reset (synchronous, active-high, sys_clk only): all outputs 0, FIFO emptied, FSM to IDLE, overflow and timeout_cnt cleared. Reset mid-transaction abandons the in-flight command; a later mem_rvalid is ignored.
- Enqueue:
  - Any cycle with read_flg or write_flg pushes {we, address, message}.
  - Both flags high in the same cycle: treated as a write.
  - FIFO full: command dropped, overflow <= 1, FIFO unchanged.
  - Push and pop in the same cycle with the FIFO full: push accepted.
- FSM states:
  - IDLE: if calib_done and FIFO non-empty, pop the head into the working registers and go to ISSUE. The pop takes 1 cycle, so mem_req rises the cycle after IDLE sees a non-empty FIFO.
  - ISSUE: hold mem_req=1 with mem_we/mem_addr/mem_wdata stable until mem_ack. On ack, mem_req <= 0 in the next cycle and the timer clears.
    - Write: go to WR_DONE.
    - Read: go to WAIT_RD.
    - Timer runs from ISSUE entry; at TIMEOUT_CYCLES go to ERR.
  - WAIT_RD: wait for mem_rvalid; latch mem_rdata and go to SEND_HI. At TIMEOUT_CYCLES go to ERR.
  - SEND_HI: tx_data = rdata[15:8], tx_valid=1; on tx_ready go to SEND_LO.
  - SEND_LO: tx_data = rdata[7:0]; on tx_ready go to IDLE.
  - WR_DONE: go to IDLE, or to SEND_ACK if the optional feature is present.
  - ERR: tx_data=ERR_BYTE, tx_valid=1; on tx_ready go to IDLE; timeout_cnt increments, saturating at 255.
- Handshakes:
  - tx_valid, once asserted, stays high with tx_data stable until tx_ready.
  - mem_req follows the same rule until mem_ack.
- Timing:
  - Best-case read latency, flag to first tx_valid: 3 cycles plus controller latency.
  - Bytes are sent MSB first, matching the upstream {hi, lo} message order.
- calib_done low: IDLE does not pop; commands queue, then overflow. calib_done falling mid-transaction has no effect on the current transaction.
- Timer: 16-bit counter, compared against TIMEOUT_CYCLES-1.

Optional Feature:
- Macro: PSRAM_BRIDGE_WRITE_ACK_EN.
- Defined: after a write completes, WR_DONE goes to SEND_ACK, which sends byte 8'h4B via valid/ready, then returns to IDLE.
- Undefined: WR_DONE goes directly to IDLE and writes produce no UART output; the SEND_ACK state is not compiled.

Decomposition:
- Package psram_bridge_pkg:
  - FSM state enum: IDLE, ISSUE, WAIT_RD, SEND_HI, SEND_LO, WR_DONE, SEND_ACK, ERR.
  - Command struct typedef: we, addr[23:0], data[15:0].
  - Constants: ACK_BYTE=8'h4B, ADDR_W=24, DATA_W=16.
- One sub-module, psram_cmd_fifo:
  - Synchronous single-clock FIFO of the command struct, DEPTH parameter.
  - Pointers one bit wider than needed for the full/empty distinction.
  - Outputs full, empty and head data; the pop is registered.

Test Plan:
- Reset, then calib_done=1; write_flg with address=24'h000010, message=16'hBEEF; ack after 5 cycles -> one mem_req with mem_we=1, mem_addr=000010, mem_wdata=BEEF, held until ack; no tx_valid (macro off) or a single 8'h4B (macro on).
- read_flg with address=24'h000010; mem_rvalid with rdata=16'hBEEF after 10 cycles; tx_ready stalled 3 cycles per byte -> tx bytes 8'hBE then 8'hEF, each held stable through the stall.
- calib_done=0; issue 5 reads at FIFO_DEPTH=4 -> no mem_req, overflow=1 after the 5th; raise calib_done -> exactly 4 reads executed in order.
- read with no mem_rvalid -> ERR_BYTE 8'h45 sent TIMEOUT_CYCLES after ack, timeout_cnt=1; the next queued command then executes normally.
- read_flg and write_flg in the same cycle -> a single write is enqueued; sys_rst asserted during WAIT_RD -> outputs 0, busy=0; a late mem_rvalid produces no tx_valid.
